// File: rtl/bitserial_gate_ctrl.sv
// Bit-serial sequencer: runs a WIDTH-bit bitwise AND/OR/XOR/XNOR through one
// external 1-bit gate, LSB first, and registers the assembled result.
module bitserial_gate_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             gate_a,
  output logic             gate_b,
  output logic [1:0]       gate_op,
  input  logic             gate_y
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-2:0] r_r_sh;
  logic [WIDTH-1:0] r_result;
  logic [1:0]       r_op;
  logic [CW-1:0]    r_cnt;
  logic             w_last;
  logic [WIDTH-1:0] w_r_nxt;

  assign w_last = (r_cnt == LAST_BIT);
  // Only the upper WIDTH-1 partial bits need storing; the newest bit comes
  // straight from the gate on the capturing edge.
  assign w_r_nxt = {gate_y, r_r_sh};

  // NOTE: asynchronous active-low reset sits in the sensitivity list so the
  // state clears the moment rst_n falls, without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns w_state_nxt and no latch forms.
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_r_sh   <= '0;
      r_result <= '0;
      r_op     <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a_sh <= A;
            r_b_sh <= B;
            r_op   <= op;
            r_cnt  <= '0;
          end
        end
        S_RUN: begin
          r_a_sh <= {1'b0, r_a_sh[WIDTH-1:1]};
          r_b_sh <= {1'b0, r_b_sh[WIDTH-1:1]};
          r_r_sh <= w_r_nxt[WIDTH-1:1];
          if (w_last) begin
            r_result <= w_r_nxt;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy    = (r_state != S_IDLE);
  assign done    = (r_state == S_DONE);
  assign result  = r_result;
  assign gate_a  = (r_state == S_RUN) & r_a_sh[0];
  assign gate_b  = (r_state == S_RUN) & r_b_sh[0];
  assign gate_op = r_op;

endmodule

// File: doc/bitserial_gate_ctrl.md
# bitserial_gate_ctrl

Bit-serial sequencer that computes a WIDTH-bit bitwise logic operation (AND/OR/XOR/XNOR) on two operands using one external 1-bit, 2-input gate unit. It latches the operands on a start request, presents one bit pair to the gate per clock (LSB first), and shifts the gate output into a result register. It sits between a requester (testbench or control unit) and the lab's single-bit gate datapath, so one gate instance can serve full-width operations.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- op  input  2  operation: 00 AND, 01 OR, 10 XOR, 11 XNOR; sampled with start.
- A  input  WIDTH  operand A; sampled with start.
- B  input  WIDTH  operand B; sampled with start.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse; result valid.
- result  output  WIDTH  registered result; holds until the next completed operation.
- gate_a  output  1  bit to gate input I1.
- gate_b  output  1  bit to gate input I2.
- gate_op  output  2  latched op, drives gate select.
- gate_y  input  1  gate output O; combinational from gate_a/gate_b/gate_op, sampled at clk edge.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: busy=0, done=0, gate_a=gate_b=0. On edge with start=1: a_sh<=A, b_sh<=B, op_r<=op, cnt<=0, -> RUN. start=0: stay.
- RUN: gate_a=a_sh[0], gate_b=b_sh[0], gate_op=op_r. Each edge: r_sh<={gate_y, r_sh[WIDTH-1:1]}; a_sh, b_sh shift right by 1 (zero fill); cnt<=cnt+1. On the edge where cnt==WIDTH-1: result<={gate_y, r_sh[WIDTH-1:1]}, -> DONE.
- DONE: done=1, busy=1 for exactly one cycle; unconditional -> IDLE. start in DONE is ignored (not queued).
- start, op, A, B changes while busy have no effect.
- cnt width: clog2(WIDTH) bits; never wraps (terminal at WIDTH-1).
- gate_op holds op_r in all states (reset 00).
- result changes only on the RUN->DONE edge; never shows partial values.

## Timing
- Reset (rst_n=0, async): state=IDLE, busy=0, done=0, result=0, gate_a=0, gate_b=0, gate_op=00, all internal registers 0. Applies immediately, mid-operation included; an interrupted operation is discarded, result keeps its reset value 0.
- Release: first active edge after rst_n rises may accept start.
- Latency: start sampled at edge E0; bit i presented during cycle after edge E0+i (i=0..WIDTH-1); done high in the cycle after edge E0+WIDTH, i.e. WIDTH+1 cycles after acceptance.
- Throughput: one operation per WIDTH+2 cycles (RUN WIDTH, DONE 1, IDLE >=1).
- busy rises the cycle after the accepting edge, falls the cycle after done.
- gate_y must settle within one clock period of gate_a/gate_b changes; no handshake with the gate.

## Test plan
- Reset, WIDTH=8, op=10, A=8'hA5, B=8'h0F, start 1 cycle -> gate_a sequence 1,0,1,0,0,1,0,1; done pulse 9 cycles after accepting edge; result=8'hAA; busy high 9 cycles.
- op=00 A=8'hFF B=8'h3C -> result 8'h3C; op=01 A=8'h80 B=8'h01 -> 8'h81; op=11 A=8'h00 B=8'h00 -> 8'hFF; each done exactly one cycle.
- Mid-run start=1 with A=8'h00, B=8'hFF, op=01 while busy -> ignored; first op's result unchanged (8'hAA for the XOR case); no extra done pulse.
- start held high continuously -> operations back-to-back, done every 10 cycles, start in DONE not accepted.
- rst_n low at RUN cycle 4 -> busy, done, result, gate_a, gate_b, gate_op all 0 immediately (before next edge); after release a new XOR A=8'h01 B=8'h00 -> result 8'h01.
- WIDTH=2, op=10, A=2'b10, B=2'b11 -> result 2'b01, done 3 cycles after acceptance.
